// File: rtl/hood_mode_ctrl_if.sv
// Button and status bundle for the cooker hood mode controller.
// The master side (panel/bench) drives the press pulses; the slave side
// (controller) drives the registered status outputs.
interface hood_mode_ctrl_if;
    logic       power_btn;
    logic       lvl1_btn;
    logic       lvl2_btn;
    logic       lvl3_btn;
    logic       clean_btn;
    logic       machine_state;
    logic [1:0] fan_level;
    logic       clean_active;
    logic [7:0] countdown;
    logic       l3_used;

    modport master (
        output power_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn,
        input  machine_state, fan_level, clean_active, countdown, l3_used
    );

    modport slave (
        input  power_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn,
        output machine_state, fan_level, clean_active, countdown, l3_used
    );
endinterface

// File: rtl/hood_mode_ctrl.sv
// Cooker hood mode controller: power/level/clean sequencing with timed
// hurricane (L3) and self-clean runs counted in one-second ticks.
// Optional macro HOOD_DELAY_OFF_EN adds a delayed shut-off state that runs
// the fan at level 1 for DELAY_S seconds after power is pressed in L1/L2.
//
// state      | meaning
// -----------+------------------------------------------------------
// OFF        | hood off, all outputs 0, hurricane allowance restored
// STANDBY    | powered, fan stopped, waiting for a level/clean press
// L1 / L2    | continuous extraction at level 1 / 2
// L3         | hurricane, timed, once per power-on session
// CLEAN      | self-clean run, timed, fan stopped
// DELAY_OFF  | level-1 run-down before OFF (HOOD_DELAY_OFF_EN only)
module hood_mode_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int L3_S     = 60,
    parameter int CLEAN_S  = 180,
    parameter int DELAY_S  = 10
) (
    input  logic              clk,
    input  logic              rst,
    hood_mode_ctrl_if.slave   hood
);

    localparam int            TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_STANDBY   = 3'd1,
        S_L1        = 3'd2,
        S_L2        = 3'd3,
        S_L3        = 3'd4,
        S_CLEAN     = 3'd5,
        S_DELAY_OFF = 3'd6
    } state_t;

    state_t        r_state, w_next_state;
    logic [TW-1:0] r_tick, w_next_tick;
    logic [7:0]    r_countdown, w_next_cd;
    logic          r_l3_used, w_next_l3;
    logic          r_machine_state, r_clean_active;
    logic [1:0]    r_fan_level, w_next_fan;

    // Priority-resolved presses: only the highest-priority button survives
    logic w_pwr, w_l3, w_l2, w_l1, w_cl;
    assign w_pwr = hood.power_btn;
    assign w_l3  = ~w_pwr & hood.lvl3_btn;
    assign w_l2  = ~w_pwr & ~hood.lvl3_btn & hood.lvl2_btn;
    assign w_l1  = ~w_pwr & ~hood.lvl3_btn & ~hood.lvl2_btn & hood.lvl1_btn;
    assign w_cl  = ~w_pwr & ~hood.lvl3_btn & ~hood.lvl2_btn & ~hood.lvl1_btn
                   & hood.clean_btn;

    logic w_wrap, w_cd_last;
    assign w_wrap    = (r_tick == TICK_LAST);
    assign w_cd_last = (r_countdown == 8'd1);

    // Next-state, timer and hurricane-allowance decode
    always_comb begin
        w_next_state = r_state;
        w_next_cd    = r_countdown;
        w_next_tick  = '0;
        w_next_l3    = r_l3_used;
        unique case (r_state)
            S_OFF: begin
                if (w_pwr) w_next_state = S_STANDBY;
            end
            S_STANDBY: begin
                if (w_pwr) begin
                    w_next_state = S_OFF;
                    w_next_l3    = 1'b0;
                end else if (w_l3 && !r_l3_used) begin
                    w_next_state = S_L3;
                    w_next_cd    = 8'(L3_S);
                    w_next_l3    = 1'b1;
                end else if (w_l2) begin
                    w_next_state = S_L2;
                end else if (w_l1) begin
                    w_next_state = S_L1;
                end else if (w_cl) begin
                    w_next_state = S_CLEAN;
                    w_next_cd    = 8'(CLEAN_S);
                end
            end
            S_L1, S_L2: begin
                if (w_pwr) begin
`ifdef HOOD_DELAY_OFF_EN
                    w_next_state = S_DELAY_OFF;
                    w_next_cd    = 8'(DELAY_S);
`else
                    w_next_state = S_OFF;
                    w_next_l3    = 1'b0;
`endif
                end else if (w_l3 && !r_l3_used) begin
                    w_next_state = S_L3;
                    w_next_cd    = 8'(L3_S);
                    w_next_l3    = 1'b1;
                end else if (w_l2) begin
                    w_next_state = S_L2;
                end else if (w_l1) begin
                    w_next_state = S_L1;
                end
            end
            S_L3, S_CLEAN: begin
                if (w_wrap) begin
                    w_next_cd = r_countdown - 8'd1;
                    if (w_cd_last) w_next_state = S_STANDBY;
                end else begin
                    w_next_tick = r_tick + 1'b1;
                end
            end
`ifdef HOOD_DELAY_OFF_EN
            S_DELAY_OFF: begin
                if (w_pwr) begin
                    w_next_state = S_OFF;
                    w_next_cd    = 8'd0;
                    w_next_l3    = 1'b0;
                end else if (w_wrap) begin
                    w_next_cd = r_countdown - 8'd1;
                    if (w_cd_last) begin
                        w_next_state = S_OFF;
                        w_next_l3    = 1'b0;
                    end
                end else begin
                    w_next_tick = r_tick + 1'b1;
                end
            end
`endif
            default: begin
                w_next_state = S_OFF;
                w_next_cd    = 8'd0;
                w_next_l3    = 1'b0;
            end
        endcase
    end

    // Fan level decode of the upcoming state, registered below
    always_comb begin
        w_next_fan = 2'd0;
        unique case (w_next_state)
            S_L1, S_DELAY_OFF: w_next_fan = 2'd1;
            S_L2:              w_next_fan = 2'd2;
            S_L3:              w_next_fan = 2'd3;
            default:           w_next_fan = 2'd0;
        endcase
    end

    // State, timers and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_OFF;
            r_tick          <= '0;
            r_countdown     <= 8'd0;
            r_l3_used       <= 1'b0;
            r_machine_state <= 1'b0;
            r_clean_active  <= 1'b0;
            r_fan_level     <= 2'd0;
        end else begin
            r_state         <= w_next_state;
            r_tick          <= w_next_tick;
            r_countdown     <= w_next_cd;
            r_l3_used       <= w_next_l3;
            r_machine_state <= (w_next_state != S_OFF);
            r_clean_active  <= (w_next_state == S_CLEAN);
            r_fan_level     <= w_next_fan;
        end
    end

    assign hood.machine_state = r_machine_state;
    assign hood.fan_level     = r_fan_level;
    assign hood.clean_active  = r_clean_active;
    assign hood.countdown     = r_countdown;
    assign hood.l3_used       = r_l3_used;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed bench for hood_mode_ctrl with short timing parameters.
module tb_hood_mode_ctrl;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    hood_mode_ctrl_if u_if ();

    hood_mode_ctrl #(
        .TICK_DIV (4),
        .L3_S     (3),
        .CLEAN_S  (5),
        .DELAY_S  (2)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .hood (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive buttons {power, lvl3, lvl2, lvl1, clean} for one edge
    task automatic press(input logic [4:0] b);
        u_if.power_btn = b[4];
        u_if.lvl3_btn  = b[3];
        u_if.lvl2_btn  = b[2];
        u_if.lvl1_btn  = b[1];
        u_if.clean_btn = b[0];
        @(posedge clk); #1;
        u_if.power_btn = 1'b0;
        u_if.lvl3_btn  = 1'b0;
        u_if.lvl2_btn  = 1'b0;
        u_if.lvl1_btn  = 1'b0;
        u_if.clean_btn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    localparam logic [4:0] B_PWR = 5'b10000;
    localparam logic [4:0] B_L3  = 5'b01000;
    localparam logic [4:0] B_L2  = 5'b00100;
    localparam logic [4:0] B_L1  = 5'b00010;
    localparam logic [4:0] B_CL  = 5'b00001;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        u_if.power_btn = 1'b0;
        u_if.lvl3_btn  = 1'b0;
        u_if.lvl2_btn  = 1'b0;
        u_if.lvl1_btn  = 1'b0;
        u_if.clean_btn = 1'b0;
        @(posedge clk); #1;
        // power press coincident with reset must be dropped
        press(B_PWR);
        rst = 1'b0;
        check("rst_ms",    int'(u_if.machine_state), 0);
        check("rst_fan",   int'(u_if.fan_level), 0);
        check("rst_cd",    int'(u_if.countdown), 0);
        check("rst_l3u",   int'(u_if.l3_used), 0);
        check("rst_clean", int'(u_if.clean_active), 0);

        // OFF ignores level buttons
        press(B_L2);
        check("off_ign_ms", int'(u_if.machine_state), 0);
        press(B_PWR);
        check("stby_ms",  int'(u_if.machine_state), 1);
        check("stby_fan", int'(u_if.fan_level), 0);
        press(B_L2 | B_L1);
        check("l2_prio_fan", int'(u_if.fan_level), 2);
        press(B_CL);
        check("l2_clean_ign", int'(u_if.clean_active), 0);
        check("l2_clean_fan", int'(u_if.fan_level), 2);
        press(B_L1);
        check("l1_fan", int'(u_if.fan_level), 1);
        press(B_L1);
        check("l1_same_noop", int'(u_if.fan_level), 1);

        // Hurricane: 3 s * 4 cycles, power ignored mid-run
        press(B_L3);
        check("l3_fan", int'(u_if.fan_level), 3);
        check("l3_cd",  int'(u_if.countdown), 3);
        check("l3_used", int'(u_if.l3_used), 1);
        idle(3);
        check("l3_cd_c3", int'(u_if.countdown), 3);
        press(B_PWR);
        check("l3_cd_c4", int'(u_if.countdown), 2);
        check("l3_pwr_ign", int'(u_if.fan_level), 3);
        idle(7);
        check("l3_cd_c11", int'(u_if.countdown), 1);
        check("l3_fan_c11", int'(u_if.fan_level), 3);
        idle(1);
        check("l3_exit_fan", int'(u_if.fan_level), 0);
        check("l3_exit_cd",  int'(u_if.countdown), 0);
        check("l3_exit_ms",  int'(u_if.machine_state), 1);
        press(B_L3);
        check("l3_reuse_fan", int'(u_if.fan_level), 0);
        check("l3_reuse_l3u", int'(u_if.l3_used), 1);

        // Self-clean: 5 s * 4 cycles
        press(B_CL);
        check("cl_active", int'(u_if.clean_active), 1);
        check("cl_cd",     int'(u_if.countdown), 5);
        check("cl_fan",    int'(u_if.fan_level), 0);
        idle(3);
        press(B_PWR);
        check("cl_cd_c4",  int'(u_if.countdown), 4);
        check("cl_pwr_ign", int'(u_if.machine_state), 1);
        idle(15);
        check("cl_cd_c19", int'(u_if.countdown), 1);
        check("cl_act_c19", int'(u_if.clean_active), 1);
        idle(1);
        check("cl_exit_act", int'(u_if.clean_active), 0);
        check("cl_exit_cd",  int'(u_if.countdown), 0);
        check("cl_exit_ms",  int'(u_if.machine_state), 1);

        // Simultaneous presses in L1: power wins
        press(B_L1);
        check("l1b_fan", int'(u_if.fan_level), 1);
        press(B_PWR | B_L3 | B_L1);
`ifdef HOOD_DELAY_OFF_EN
        check("dly_fan", int'(u_if.fan_level), 1);
        check("dly_cd",  int'(u_if.countdown), 2);
        check("dly_ms",  int'(u_if.machine_state), 1);
        idle(7);
        check("dly_cd_c7", int'(u_if.countdown), 1);
        check("dly_ms_c7", int'(u_if.machine_state), 1);
        idle(1);
        check("dly_off_ms",  int'(u_if.machine_state), 0);
        check("dly_off_l3u", int'(u_if.l3_used), 0);
        // Second power press cuts the run-down short
        press(B_PWR);
        press(B_L2);
        press(B_PWR);
        check("dly2_cd", int'(u_if.countdown), 2);
        press(B_PWR);
        check("dly2_off_ms", int'(u_if.machine_state), 0);
        check("dly2_off_cd", int'(u_if.countdown), 0);
`else
        check("pwr_off_ms",  int'(u_if.machine_state), 0);
        check("pwr_off_fan", int'(u_if.fan_level), 0);
        check("pwr_off_l3u", int'(u_if.l3_used), 0);
`endif

        // New session: hurricane available again
        press(B_PWR);
        press(B_L3);
        check("ses_l3_fan", int'(u_if.fan_level), 3);
        check("ses_l3_cd",  int'(u_if.countdown), 3);
        idle(4);
        check("ses_l3_cd2", int'(u_if.countdown), 2);

        // Reset mid-hurricane
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rstl3_ms",  int'(u_if.machine_state), 0);
        check("rstl3_fan", int'(u_if.fan_level), 0);
        check("rstl3_cd",  int'(u_if.countdown), 0);
        check("rstl3_l3u", int'(u_if.l3_used), 0);
        press(B_PWR);
        press(B_L3);
        check("rstl3_again_fan", int'(u_if.fan_level), 3);
        check("rstl3_again_cd",  int'(u_if.countdown), 3);
        // Tick counter restarted on entry: full 4 cycles before decrement
        idle(3);
        check("rstl3_tick_c3", int'(u_if.countdown), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hood_mode_ctrl.md
HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per one-second tick.
REQ-002 SHALL have parameter L3_S, default 60, meaning level-3 (hurricane) run time in seconds.
REQ-003 SHALL have parameter CLEAN_S, default 180, meaning self-clean run time in seconds.
REQ-004 SHALL have parameter DELAY_S, default 10, meaning delayed-off run time in seconds (used only with HOOD_DELAY_OFF_EN).
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  one clock; reset is synchronous and active-high.
REQ-007 SHALL have ports power_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn  input  1 each  debounced one-cycle press pulses.
REQ-008 SHALL have port machine_state  output  1  high in every state except OFF; drives the light block enable.
REQ-009 SHALL have port fan_level  output  2  0 = stopped, 1..3 = extraction level.
REQ-010 SHALL have port clean_active  output  1  high only in CLEAN.
REQ-011 SHALL have port countdown  output  8  remaining whole seconds in a timed state, else 0.
REQ-012 SHALL have port l3_used  output  1  hurricane already consumed in this power-on session.

Function
REQ-013 SHALL implement states OFF, STANDBY, L1, L2, L3, CLEAN, DELAY_OFF; all outputs registered.
REQ-014 fan_level SHALL be 0 in OFF/STANDBY/CLEAN, 1 in L1 and DELAY_OFF, 2 in L2, 3 in L3.
REQ-015 Simultaneous presses SHALL resolve by priority power > lvl3 > lvl2 > lvl1 > clean; lower ones are dropped.
REQ-016 OFF: power_btn -> STANDBY; all other buttons ignored.
REQ-017 STANDBY: lvl1 -> L1, lvl2 -> L2, lvl3 -> L3 if l3_used=0, clean -> CLEAN, power -> OFF.
REQ-018 L1/L2: lvl1/lvl2 switch between L1 and L2 (same-level press is a no-op); lvl3 -> L3 if l3_used=0; clean ignored; power -> OFF (or DELAY_OFF per REQ-029).
REQ-019 L3 entry SHALL set l3_used=1 and load countdown=L3_S; all buttons including power ignored in L3; at countdown 0 -> STANDBY.
REQ-020 lvl3 with l3_used=1 SHALL be ignored (state unchanged).
REQ-021 CLEAN entry SHALL load countdown=CLEAN_S; all buttons ignored; at countdown 0 -> STANDBY.
REQ-022 Second tick: a counter 0..TICK_DIV-1, cleared on every entry to a timed state so the first second is a full TICK_DIV cycles; countdown decrements on wrap.
REQ-023 Timed-state exit SHALL occur on the same edge countdown reaches 0 -> next cycle shows new state with countdown=0.
REQ-024 Entering OFF SHALL clear l3_used.
REQ-025 L3_S, CLEAN_S, DELAY_S SHALL each be 1..255; TICK_DIV >= 2.

Reset
REQ-026 rst=1 at a rising edge SHALL force OFF, fan_level=0, machine_state=0, clean_active=0, countdown=0, l3_used=0, tick counter=0, including mid-L3/CLEAN/DELAY_OFF.
REQ-027 Button pulses coincident with rst SHALL be ignored.

Configuration
REQ-028 Macro HOOD_DELAY_OFF_EN SHALL select delayed shut-off.
REQ-029 With HOOD_DELAY_OFF_EN defined: power in L1/L2 -> DELAY_OFF, countdown=DELAY_S; a second power press -> OFF immediately; other buttons ignored; countdown 0 -> OFF.
REQ-030 Without HOOD_DELAY_OFF_EN: power in L1/L2 -> OFF on the next edge; DELAY_OFF logic is not synthesised.

Verification (TICK_DIV=4, L3_S=3, CLEAN_S=5, DELAY_S=2)
REQ-031 rst, then power_btn -> machine_state=1, fan_level=0; lvl2_btn -> fan_level=2.
REQ-032 STANDBY, lvl3_btn -> fan_level=3, countdown=3, l3_used=1; after 12 cycles -> STANDBY, fan_level=0; lvl3_btn again -> no change.
REQ-033 STANDBY, clean_btn -> clean_active=1, countdown 5..1 each 4 cycles; power_btn mid-run ignored; after 20 cycles -> STANDBY.
REQ-034 L1, lvl1_btn+lvl3_btn+power_btn same cycle -> power wins: OFF (no macro) or DELAY_OFF countdown=2 (macro), OFF after 8 cycles.
REQ-035 rst during L3 with countdown=2 -> next cycle all outputs 0, l3_used=0; power then lvl3 -> L3 accepted.
REQ-036 Power-off/on cycle after L3 use -> l3_used=0, lvl3 accepted.
